// File: rtl/md_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : md_issue_ctrl_pkg
// Description : Shared encodings for the multiply/divide issue controller:
//               instruction classes, MDop codes, FSM states and latencies.
// Revision    : 1.0 - initial release
// ============================================================================
package md_issue_ctrl_pkg;

  // E-stage MD instruction classes
  localparam logic [3:0] c_cls_none  = 4'd0;
  localparam logic [3:0] c_cls_multu = 4'd1;
  localparam logic [3:0] c_cls_mult  = 4'd2;
  localparam logic [3:0] c_cls_divu  = 4'd3;
  localparam logic [3:0] c_cls_div   = 4'd4;
  localparam logic [3:0] c_cls_madd  = 4'd5;
  localparam logic [3:0] c_cls_mfhi  = 4'd6;
  localparam logic [3:0] c_cls_mflo  = 4'd7;
  localparam logic [3:0] c_cls_mthi  = 4'd8;
  localparam logic [3:0] c_cls_mtlo  = 4'd9;

  // MDop codes understood by the MD unit
  localparam logic [2:0] c_mdop_multu = 3'b000;
  localparam logic [2:0] c_mdop_mult  = 3'b001;
  localparam logic [2:0] c_mdop_divu  = 3'b010;
  localparam logic [2:0] c_mdop_div   = 3'b011;
  localparam logic [2:0] c_mdop_madd  = 3'b100;

  // Issue FSM states
  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_issued = 2'd1;
  localparam logic [1:0] c_st_busy   = 2'd2;
  localparam logic [1:0] c_st_settle = 2'd3;

  // Default latencies of the MD unit
  localparam int c_mul_lat_def = 5;
  localparam int c_div_lat_def = 10;
  localparam int c_timeout_def = 31;

  // Map an operation class (1..5) onto its MDop code
  function automatic logic [2:0] class_to_mdop(input logic [3:0] cls);
    logic [2:0] op;
    op = c_mdop_multu;
    case (cls)
      c_cls_mult:  op = c_mdop_mult;
      c_cls_divu:  op = c_mdop_divu;
      c_cls_div:   op = c_mdop_div;
      c_cls_madd:  op = c_mdop_madd;
      default:     op = c_mdop_multu;
    endcase
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/md_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : md_issue_ctrl
// Description : E-stage initiator for the multiply/divide unit. Issues
//               operations, stalls later MD instructions until HI/LO settle,
//               serves mfhi/mflo and checks the unit's Busy latency.
// Revision    : 1.0 - initial release
// ============================================================================
module md_issue_ctrl
  import md_issue_ctrl_pkg::*;
#(
  parameter int MUL_LAT = c_mul_lat_def,
  parameter int DIV_LAT = c_div_lat_def,
  parameter int TIMEOUT = c_timeout_def
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [3:0]  md_class,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_busy,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  output logic        md_start,
  output logic [2:0]  md_op,
  output logic        md_hiwrite,
  output logic        md_lowrite,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic        stall,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        timeout_err,
  output logic        lat_err
);

  localparam logic [4:0] c_mul_lat = 5'(MUL_LAT);
  localparam logic [4:0] c_div_lat = 5'(DIV_LAT);
  localparam logic [4:0] c_timeout = 5'(TIMEOUT);

  logic [1:0] r_state;
  logic [4:0] r_lat_cnt;
  logic [4:0] r_exp_lat;
  logic       r_timeout_err;
  logic       r_lat_err;

  logic       w_md;
  logic       w_is_op;
  logic       w_idle_md;
  logic [4:0] w_lat_inc;

  assign w_md      = instr_valid && (md_class != c_cls_none) && (md_class <= c_cls_mtlo);
  assign w_is_op   = (md_class != c_cls_none) && (md_class <= c_cls_madd);
  assign w_idle_md = w_md && (r_state == c_st_idle);

  // Busy-cycle counter increment, held at the timeout value once reached
  assign w_lat_inc = (r_lat_cnt >= c_timeout) ? c_timeout : r_lat_cnt + 5'd1;

  // Strobes only fire when an MD instruction is accepted in IDLE
  assign stall      = w_md && (r_state != c_st_idle);
  assign md_op      = w_is_op ? class_to_mdop(md_class) : c_mdop_multu;
  assign md_start   = w_idle_md && w_is_op;
  assign md_hiwrite = w_idle_md && (md_class == c_cls_mthi);
  assign md_lowrite = w_idle_md && (md_class == c_cls_mtlo);
  assign md_a       = rs_val;
  assign md_b       = rt_val;

  assign timeout_err = r_timeout_err;
  assign lat_err     = r_lat_err;

  // mfhi/mflo read path straight from the unit's HI/LO
  always_comb begin
    rd_data  = 32'd0;
    rd_valid = 1'b0;
    if (w_idle_md && (md_class == c_cls_mfhi)) begin
      rd_data  = hi_in;
      rd_valid = 1'b1;
    end else if (w_idle_md && (md_class == c_cls_mflo)) begin
      rd_data  = lo_in;
      rd_valid = 1'b1;
    end
  end

  // Issue FSM with inline Busy-latency checker and sticky error flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= c_st_idle;
      r_lat_cnt     <= 5'd0;
      r_exp_lat     <= 5'd0;
      r_timeout_err <= 1'b0;
      r_lat_err     <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (md_start) begin
            r_exp_lat <= ((md_class == c_cls_divu) || (md_class == c_cls_div)) ? c_div_lat : c_mul_lat;
            r_lat_cnt <= 5'd0;
            r_state   <= c_st_issued;
          end
        end
        c_st_issued: begin
          // Busy normally rises here; count it so the total matches the unit
          if (md_busy) begin
            r_lat_cnt <= w_lat_inc;
          end
          r_state <= c_st_busy;
        end
        c_st_busy: begin
          if (md_busy) begin
            r_lat_cnt <= w_lat_inc;
            if (w_lat_inc >= c_timeout) begin
              r_timeout_err <= 1'b1;
              r_state       <= c_st_settle;
            end
          end else begin
            if (r_lat_cnt != r_exp_lat) begin
              r_lat_err <= 1'b1;
            end
            r_state <= c_st_settle;
          end
        end
        c_st_settle: begin
          // HI/LO change on the Busy falling edge; give them a cycle to settle
          r_state <= c_st_idle;
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_md_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_issue_ctrl
// Description : Scoreboard bench for md_issue_ctrl with a behavioural MD unit
//               whose Busy length is adjustable per operation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [3:0]  md_class;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        md_busy = 1'b0;
  logic [31:0] hi_in;
  logic [31:0] lo_in;
  logic        md_start;
  logic [2:0]  md_op;
  logic        md_hiwrite;
  logic        md_lowrite;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        stall;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        timeout_err;
  logic        lat_err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_rd[$];
  logic [2:0]  exp_op[$];

  md_issue_ctrl dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .md_class(md_class),
    .rs_val(rs_val), .rt_val(rt_val), .md_busy(md_busy), .hi_in(hi_in), .lo_in(lo_in),
    .md_start(md_start), .md_op(md_op), .md_hiwrite(md_hiwrite), .md_lowrite(md_lowrite),
    .md_a(md_a), .md_b(md_b), .stall(stall), .rd_data(rd_data), .rd_valid(rd_valid),
    .timeout_err(timeout_err), .lat_err(lat_err)
  );

  always #5 clk = ~clk;

  // Behavioural MD unit: Busy high for busy_len cycles starting the cycle after start
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [63:0] m_pend = 64'd0;
  int          m_rem = 0;
  int          busy_len = 5;
  assign hi_in = m_hi;
  assign lo_in = m_lo;

  function automatic logic [63:0] compute(input logic [2:0] op, input logic [31:0] a, b, hi, lo);
    logic [63:0] r;
    case (op)
      3'b000:  r = {32'd0, a} * {32'd0, b};
      3'b001:  r = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      3'b010:  r = {a % b, a / b};
      3'b011:  r = {$signed(a) % $signed(b), $signed(a) / $signed(b)};
      default: r = {hi, lo} + ($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    if (md_start) begin
      m_pend  <= compute(md_op, md_a, md_b, m_hi, m_lo);
      m_rem   <= busy_len;
      md_busy <= 1'b1;
    end else if (md_busy) begin
      if (m_rem <= 1) begin
        md_busy <= 1'b0;
        m_hi    <= m_pend[63:32];
        m_lo    <= m_pend[31:0];
      end
      m_rem <= m_rem - 1;
    end
    if (md_hiwrite) m_hi <= md_a;
    if (md_lowrite) m_lo <= md_a;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // Monitor: pop expectations whenever the DUT presents read data or a start
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (exp_rd.size() == 0) chk("unexpected rd_valid", 32'd1, 32'd0);
      else chk("rd_data", rd_data, exp_rd.pop_front());
    end
    if (md_start === 1'b1) begin
      if (exp_op.size() == 0) chk("unexpected md_start", 32'd1, 32'd0);
      else chk("md_op", 32'(md_op), 32'(exp_op.pop_front()));
    end
  end

  // Present one instruction, wait until it is accepted, check stall count
  task automatic present(input logic [3:0] cls, input logic [31:0] a, b,
                         input logic [31:0] exp, input int exp_stall, input string nm);
    int n;
    if (cls >= 4'd1 && cls <= 4'd5) exp_op.push_back(3'(cls - 4'd1));
    if (cls == 4'd6 || cls == 4'd7) exp_rd.push_back(exp);
    instr_valid = 1'b1; md_class = cls; rs_val = a; rt_val = b;
    n = 0;
    @(negedge clk);
    while (stall && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({nm, " stall cycles"}, 32'(n), 32'(exp_stall));
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    instr_valid = 1'b0; md_class = 4'd0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input logic exp_to, input logic exp_le, input string nm);
    instr_valid = 1'b0; md_class = 4'd0;
    @(negedge clk);
    chk({nm, " timeout_err"}, 32'(timeout_err), 32'(exp_to));
    chk({nm, " lat_err"}, 32'(lat_err), 32'(exp_le));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; instr_valid = 1'b0; md_class = 4'd0; rs_val = 32'd0; rt_val = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset md_start", 32'(md_start), 32'd0);
    chk("reset rd_valid", 32'(rd_valid), 32'd0);
    chk("reset timeout_err", 32'(timeout_err), 32'd0);
    chk("reset lat_err", 32'(lat_err), 32'd0);
    @(posedge clk); #1 reset = 1'b1;

    // MULT -3 * 7, back-to-back MFLO then MFHI
    busy_len = 5;
    present(4'd2, 32'hFFFFFFFD, 32'd7, 32'd0, 0, "mult");
    present(4'd7, 32'd0, 32'd0, 32'hFFFFFFEB, 7, "mflo after mult");
    present(4'd6, 32'd0, 32'd0, 32'hFFFFFFFF, 0, "mfhi after mult");
    chk_flags(1'b0, 1'b0, "mult");

    // DIVU 100 / 7
    busy_len = 10;
    present(4'd3, 32'd100, 32'd7, 32'd0, 0, "divu");
    present(4'd6, 32'd0, 32'd0, 32'd2, 12, "mfhi after divu");
    present(4'd7, 32'd0, 32'd0, 32'd14, 0, "mflo after divu");
    chk_flags(1'b0, 1'b0, "divu");

    // MTHI then MFHI
    instr_valid = 1'b1; md_class = 4'd8; rs_val = 32'h12345678; rt_val = 32'hCAFEF00D;
    @(negedge clk);
    chk("mthi hiwrite", 32'(md_hiwrite), 32'd1);
    chk("mthi lowrite", 32'(md_lowrite), 32'd0);
    chk("mthi md_a", md_a, 32'h12345678);
    chk("mthi md_b", md_b, 32'hCAFEF00D);
    chk("mthi stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    present(4'd6, 32'd0, 32'd0, 32'h12345678, 0, "mfhi after mthi");
    chk("hiwrite after mthi", 32'(md_hiwrite), 32'd0);

    // Busy one cycle too long: latency error, ADDs never stall
    busy_len = 6;
    present(4'd2, 32'd2, 32'd3, 32'd0, 0, "mult long");
    for (int i = 0; i < 3; i++) present(4'd0, 32'd0, 32'd0, 32'd0, 0, "add");
    present(4'd7, 32'd0, 32'd0, 32'd6, 5, "mflo after long mult");
    chk_flags(1'b0, 1'b1, "long mult");

    // Reset in the middle of an operation, then MADD issues at once
    busy_len = 10;
    present(4'd2, 32'd5, 32'd5, 32'd0, 0, "mult aborted");
    busy_len = 5;
    idle(3);
    reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    present(4'd5, 32'd4, 32'd5, 32'd0, 0, "madd after reset");
    present(4'd7, 32'd0, 32'd0, 32'd26, 7, "mflo after madd");
    chk_flags(1'b0, 1'b0, "after reset");

    // Busy stuck high: timeout, then recovery
    busy_len = 40;
    present(4'd1, 32'd1, 32'd1, 32'd0, 0, "multu stuck");
    present(4'd7, 32'd0, 32'd0, 32'd26, 32, "mflo after timeout");
    idle(12);
    chk_flags(1'b1, 1'b0, "timeout");
    busy_len = 5;
    present(4'd1, 32'd6, 32'd7, 32'd0, 0, "multu recover");
    present(4'd7, 32'd0, 32'd0, 32'd42, 7, "mflo recover");
    chk_flags(1'b1, 1'b0, "sticky timeout");

    idle(2);
    chk("pending rd expectations", 32'(exp_rd.size()), 32'd0);
    chk("pending op expectations", 32'(exp_op.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/md_issue_ctrl.md
Name: md_issue_ctrl

Overview:
- E-stage initiator for the multiply/divide unit: decodes the MD instruction class, then drives start/MDop/HIwrite/LOwrite and the A/B operands.
- Tracks each outstanding operation through the unit's Busy window and stalls any later MD-class instruction until HI/LO are settled.
- Supplies mfhi/mflo read data to E-stage writeback.
- Checks the unit's observed latency against the expected value and raises sticky error flags.

Parameters:
- MUL_LAT, 5, expected Busy-high cycles for MULT/MULTU/MADD
- DIV_LAT, 10, expected Busy-high cycles for DIV/DIVU
- TIMEOUT, 31, maximum Busy-high cycles before forced completion with error

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (reset==0 resets on posedge clk)
- instr_valid  in  1  E-stage instruction valid (already gated by flush)
- md_class  in  4  0 NONE, 1 MULTU, 2 MULT, 3 DIVU, 4 DIV, 5 MADD, 6 MFHI, 7 MFLO, 8 MTHI, 9 MTLO, others NONE
- rs_val  in  32  forwarded rs operand
- rt_val  in  32  forwarded rt operand
- md_busy  in  1  Busy from the MD unit
- hi_in  in  32  HI from the MD unit
- lo_in  in  32  LO from the MD unit
- md_start  out  1  start pulse to the MD unit
- md_op  out  3  MDop: 000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MADD
- md_hiwrite  out  1  HIwrite pulse
- md_lowrite  out  1  LOwrite pulse
- md_a  out  32  = rs_val
- md_b  out  32  = rt_val
- stall  out  1  freeze F/D/E, insert bubble into M
- rd_data  out  32  mfhi/mflo result
- rd_valid  out  1  rd_data meaningful this cycle
- timeout_err  out  1  sticky: Busy exceeded TIMEOUT
- lat_err  out  1  sticky: Busy-high count differed from expected latency

Behaviour:
- States: IDLE, ISSUED, BUSY, SETTLE (2-bit reg).
- Registers: lat_cnt (5 bits), exp_lat (5 bits).
- Reset (reset==0 at posedge): state=IDLE, lat_cnt=0, exp_lat=0, timeout_err=0, lat_err=0. Applies mid-operation too; the outstanding op is abandoned.
- md = instr_valid && md_class in 1..9.
- stall = md && state!=IDLE. Non-MD instructions never stall.
- Strobe outputs are combinational. All of md_start, md_hiwrite, md_lowrite and rd_valid are 0 unless state==IDLE && md.
- md_op = encoding of md_class when the class is 1..5, else 000.
- IDLE, class 1..5:
  - md_start=1 for one cycle.
  - exp_lat = MUL_LAT for classes 1, 2, 5; DIV_LAT for classes 3, 4.
  - lat_cnt=0; next state ISSUED.
- IDLE, MTHI: md_hiwrite=1, stay IDLE. IDLE, MTLO: md_lowrite=1, stay IDLE. md_hiwrite and md_lowrite are never both 1.
- IDLE, MFHI: rd_data=hi_in, rd_valid=1. IDLE, MFLO: rd_data=lo_in, rd_valid=1. Otherwise rd_data=0, rd_valid=0.
- ISSUED (the MD unit asserts Busy the cycle after start; this state covers that gap):
  - lat_cnt += md_busy.
  - Next state BUSY unconditionally.
- BUSY:
  - If md_busy==1: lat_cnt += 1. If lat_cnt+1 reaches TIMEOUT: timeout_err=1, next SETTLE.
  - If md_busy==0: lat_err |= (lat_cnt != exp_lat); next SETTLE.
- SETTLE:
  - One cycle, so that HI/LO (updated on the Busy falling edge) are stable before the next read.
  - Next state IDLE.
- Resulting stall for a back-to-back MD-class instruction: MUL_LAT+2 cycles (7) after a mult, DIV_LAT+2 (12) after a div.
- Simultaneous events:
  - An MD instruction in IDLE is accepted in the same cycle; there is no extra bubble.
  - A stalled instruction produces no strobes.
  - instr_valid dropping (flush) while stalled does not disturb the outstanding op.
- md_busy==1 while in IDLE is ignored and does not affect the error flags.
- lat_cnt saturates at TIMEOUT. The error flags clear only on reset.

Decomposition:
- Shared package: md_class encodings, MDop encodings (MULTU..MADD, the same values the MD unit uses), state encodings, MUL_LAT/DIV_LAT defaults.
- Single module; no sub-module needed. The latency checker stays inline (counter plus compare).

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=7, then MFLO the next cycle -> md_start=1 for 1 cycle with md_op=001; MFLO stalls exactly 7 cycles; then rd_data=0xFFFFFFEB, rd_valid=1; MFHI gives 0xFFFFFFFF; lat_err=0.
- DIVU rs=100, rt=7, then MFHI immediately -> stall for 12 cycles; MFHI=2, MFLO=14; lat_err=0.
- MTHI rs=0x12345678 in IDLE -> md_hiwrite=1 for 1 cycle, md_a=0x12345678, stall=0; a following MFHI returns 0x12345678 with no stall.
- Busy model held high for 40 cycles after MULT -> timeout_err=1 after 31 Busy-high cycles; state returns to IDLE 2 cycles later; MD instructions are accepted again.
- Busy model asserting 6 cycles for MULT -> lat_err=1 (sticky), timeout_err=0; an ADD (md_class=0) during the op never stalls.
- reset=0 during BUSY -> the next cycle has state IDLE, stall=0, both flags 0; a new MADD issues md_start immediately.
